rom_prefetch: RTL

//   Bus initiator for the asynchronous ROM port (addr / tri-state data / oe_n).

---
 rtl/rom_prefetch_pkg.sv | 20 ++
 rtl/rom_prefetch_if.sv | 28 ++
 rtl/rom_prefetch_byte_fifo.sv | 80 ++++++++
 rtl/rom_prefetch_chk.sv | 32 +++
 rtl/rom_prefetch.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/rom_prefetch_pkg.sv
// Shared definitions for the ROM prefetch initiator: bus FSM encodings,
// ROM port widths and the wait-counter width.
package rom_prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } fetch_state_e;

    localparam int ROM_DATA_W = 8;
    localparam int WAIT_CNT_W = 4;

    // True when the wait counter has reached the last cycle of an access.
    function automatic logic wait_done(input logic [WAIT_CNT_W-1:0] cnt,
                                       input logic [WAIT_CNT_W-1:0] last);
        return (cnt == last);
    endfunction

endpackage

// File: rtl/rom_prefetch_if.sv
// Bundle of the CPU-side byte stream, the jump request and the ROM port.
// master: the prefetch initiator. slave: CPU fetch logic plus ROM device.
interface rom_prefetch_if #(
    parameter int ADDR_W = 16
);
    import rom_prefetch_pkg::*;

    logic                  jump_valid;
    logic [ADDR_W-1:0]     jump_addr;
    logic                  byte_valid;
    logic                  byte_ready;
    logic [ROM_DATA_W-1:0] byte_data;
    logic [ADDR_W-1:0]     byte_addr;
    logic [ADDR_W-1:0]     rom_addr;
    logic                  rom_oe_n;
    logic [ROM_DATA_W-1:0] rom_data;

    modport master (
        input  jump_valid, jump_addr, byte_ready, rom_data,
        output byte_valid, byte_data, byte_addr, rom_addr, rom_oe_n
    );

    modport slave (
        output jump_valid, jump_addr, byte_ready, rom_data,
        input  byte_valid, byte_data, byte_addr, rom_addr, rom_oe_n
    );

endinterface

// File: rtl/rom_prefetch_byte_fifo.sv
// Synchronous prefetch queue of {address, data} pairs. Flush empties it in
// one cycle; push into a full queue and pop from an empty one are ignored.
module rom_prefetch_byte_fifo
    import rom_prefetch_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_W-1:0]     push_addr,
    input  logic [ROM_DATA_W-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [ADDR_W-1:0]     head_addr,
    output logic [ROM_DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full
);
    localparam int                PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_0   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_1   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_1   = PTR_W'(1);

    logic [ADDR_W-1:0]     addr_mem_r [DEPTH];
    logic [ROM_DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_push_s = push && (count_r != DEPTH_C);
        do_pop_s  = pop  && (count_r != CNT_0);
    end

    // Storage, pointers and fill count; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                data_mem_r[i] <= {ROM_DATA_W{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_0;
        end else begin
            if (do_push_s) begin
                addr_mem_r[wr_ptr_r] <= push_addr;
                data_mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r             <= wr_ptr_r + PTR_1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_1;
                2'b01:   count_r <= count_r - CNT_1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_addr = addr_mem_r[rd_ptr_r];
    assign head_data = data_mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = (count_r == CNT_0);
    assign full      = (count_r == DEPTH_C);

endmodule

// File: rtl/rom_prefetch_chk.sv
// Protocol checker for the ROM port and prefetch queue.
module rom_prefetch_chk #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input logic              clk,
    input logic              reset,
    input logic              rom_oe_n,
    input logic [ADDR_W-1:0] rom_addr,
    input logic              push,
    input logic [CNT_W-1:0]  count
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // ROM data is captured only while the output enable is asserted.
    a_sample_with_oe: assert property (@(posedge clk) disable iff (reset)
        push |-> !rom_oe_n);

    // Address must not move during an access.
    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (!rom_oe_n && !$past(rom_oe_n)) |-> (rom_addr == $past(rom_addr)));

    // Queue never overfills.
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= DEPTH_C);

    // Every capture is followed by a bus-turnaround cycle.
    a_turnaround: assert property (@(posedge clk) disable iff (reset)
        push |=> rom_oe_n);

endmodule

// File: rtl/rom_prefetch.sv
// ROM prefetch initiator: walks the asynchronous ROM sequentially, queues
// each byte with its address for the CPU, and restarts on a jump request.
module rom_prefetch
    import rom_prefetch_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                WAIT_CYCLES = 1,
    parameter int                FIFO_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = 16'h0000
) (
    input logic            clk,
    input logic            reset,
    rom_prefetch_if.master bus
);
    localparam int                    CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] WAIT_1    = WAIT_CNT_W'(1);
    localparam logic [ADDR_W-1:0]     ADDR_1    = ADDR_W'(1);

    fetch_state_e          state_r;
    fetch_state_e          state_next_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_r;
    logic [ADDR_W-1:0]     fetch_addr_r;
    logic [ADDR_W-1:0]     rom_addr_r;
    logic                  rom_oe_n_r;

    logic                  access_last_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  enter_access_s;
    logic                  stay_access_s;
    logic                  oe_n_next_s;

    logic [ADDR_W-1:0]     head_addr_s;
    logic [ROM_DATA_W-1:0] head_data_s;
    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;

    assign access_last_s = (state_r == ACCESS) && wait_done(wait_cnt_r, WAIT_LAST);

    // Bus FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state: a jump always passes through RECOVER so the bus turns around
    // before the new address; otherwise start an access whenever a slot is free.
    always_comb begin
        state_next_s = state_r;
        if (bus.jump_valid) begin
            state_next_s = RECOVER;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_full_s) state_next_s = ACCESS;
                    else              state_next_s = IDLE;
                end
                ACCESS: begin
                    if (access_last_s) state_next_s = RECOVER;
                    else               state_next_s = ACCESS;
                end
                RECOVER: begin
                    if (!fifo_full_s) state_next_s = ACCESS;
                    else              state_next_s = IDLE;
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Control strobes; a jump aborts the capture and discards any pop.
    always_comb begin
        push_s         = access_last_s && !bus.jump_valid;
        pop_s          = bus.byte_ready && !fifo_empty_s && !bus.jump_valid;
        flush_s        = bus.jump_valid;
        enter_access_s = (state_next_s == ACCESS) && (state_r != ACCESS);
        stay_access_s  = (state_next_s == ACCESS) && (state_r == ACCESS);
        oe_n_next_s    = (state_next_s != ACCESS);
    end

    // Registered ROM port, wait counter and sequential fetch address.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r   <= {WAIT_CNT_W{1'b0}};
            fetch_addr_r <= RESET_ADDR;
            rom_addr_r   <= RESET_ADDR;
            rom_oe_n_r   <= 1'b1;
        end else begin
            rom_oe_n_r <= oe_n_next_s;
            if (stay_access_s) begin
                wait_cnt_r <= wait_cnt_r + WAIT_1;
            end else begin
                wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            end
            if (bus.jump_valid) begin
                fetch_addr_r <= bus.jump_addr;
            end else if (push_s) begin
                fetch_addr_r <= fetch_addr_r + ADDR_1;
            end else begin
                fetch_addr_r <= fetch_addr_r;
            end
            if (enter_access_s) begin
                rom_addr_r <= fetch_addr_r;
            end else begin
                rom_addr_r <= rom_addr_r;
            end
        end
    end

    rom_prefetch_byte_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_byte_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_addr (rom_addr_r),
        .push_data (bus.rom_data),
        .pop       (pop_s),
        .flush     (flush_s),
        .head_addr (head_addr_s),
        .head_data (head_data_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    rom_prefetch_chk #(
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_chk (
        .clk      (clk),
        .reset    (reset),
        .rom_oe_n (rom_oe_n_r),
        .rom_addr (rom_addr_r),
        .push     (push_s),
        .count    (fifo_count_s)
    );

    assign bus.rom_oe_n   = rom_oe_n_r;
    assign bus.rom_addr   = rom_addr_r;
    assign bus.byte_valid = !fifo_empty_s;
    assign bus.byte_data  = head_data_s;
    assign bus.byte_addr  = head_addr_s;

endmodule
